// File: rtl/face_result_tx_queue.sv
// Circular queue of detection records, drained byte-wise (LSB byte first) to the
// UART transmitter on end-of-frame; an empty queue yields a single "no face" byte.
module face_result_tx_queue #(
  parameter int          DEPTH        = 100,
  parameter int          WORD_W       = 32,
  parameter int          NUM_WORDS    = 4,
  parameter logic [7:0]  NO_FACE_BYTE = 8'h00
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rec_valid,
  input  logic [NUM_WORDS*WORD_W-1:0]   rec_data,
  input  logic                          frame_done,
  input  logic                          tx_sent,
  output logic                          tx_send,
  output logic [7:0]                    tx_data,
  output logic                          busy,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [15:0]                   overflow_cnt
);

  localparam int REC_W = NUM_WORDS * WORD_W;
  localparam int RB    = REC_W / 8;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = (RB > 1) ? $clog2(RB) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, NONE} state_t;

  state_t            state, state_nxt;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [BW-1:0]     byte_idx;
  logic [REC_W-1:0]  shreg;
  logic              push, pop, last_byte;
  logic [CW-1:0]     count_nxt;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign last_byte = (byte_idx == BW'(RB - 1));
  assign pop       = (state == SEND) && tx_sent && last_byte;
  // A full queue still accepts a record when the head is popped in the same cycle.
  assign push      = rec_valid && ((count < CW'(DEPTH)) || pop);
  assign busy      = (state != IDLE);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    tx_send   = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: if (frame_done) state_nxt = (count != '0) ? LOAD : NONE;
      LOAD: state_nxt = SEND;
      SEND: begin
        tx_send = 1'b1;
        tx_data = shreg[7:0];
        if (pop) state_nxt = (count_nxt != '0) ? LOAD : IDLE;
      end
      NONE: begin
        tx_send = 1'b1;
        tx_data = NO_FACE_BYTE;
        if (tx_sent) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rec_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
      byte_idx     <= '0;
      shreg        <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop)  rd_ptr <= inc_ptr(rd_ptr);
      if (rec_valid && !push && (overflow_cnt != 16'hFFFF))
        overflow_cnt <= overflow_cnt + 16'd1;
      if (state == LOAD) begin
        shreg    <= mem[rd_ptr];
        byte_idx <= '0;
      end else if ((state == SEND) && tx_sent && !last_byte) begin
        // Shifting keeps the current byte at the bottom, so tx_data needs no wide mux.
        shreg    <= shreg >> 8;
        byte_idx <= byte_idx + BW'(1);
      end
    end
  end

endmodule
